// File: rtl/axi_s_ram.sv
// AXI4 slave memory: single-ID FIXED/INCR bursts up to 16 beats, full-width beats only.
// Independent write (AW/W/B) and read (AR/R) state machines share one word array.
module axi_s_ram #(
    parameter int WIDTH_ID  = 1,
    parameter int WIDTH_AD  = 32,
    parameter int WIDTH_DA  = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic [WIDTH_ID-1:0]   S_AXI_AWID,
    input  logic [WIDTH_AD-1:0]   S_AXI_AWADDR,
    input  logic [3:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [WIDTH_DA-1:0]   S_AXI_WDATA,
    input  logic [WIDTH_DA/8-1:0] S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [WIDTH_ID-1:0]   S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [WIDTH_ID-1:0]   S_AXI_ARID,
    input  logic [WIDTH_AD-1:0]   S_AXI_ARADDR,
    input  logic [3:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [WIDTH_ID-1:0]   S_AXI_RID,
    output logic [WIDTH_DA-1:0]   S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);
    localparam int         BYTES   = WIDTH_DA / 8;
    localparam int         IDX_W   = $clog2(MEM_WORDS);
    localparam logic [2:0] SIZE_OK = 3'($clog2(BYTES));

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [WIDTH_DA-1:0] mem [MEM_WORDS];

    w_state_t           w_state;
    logic [IDX_W-1:0]   w_idx;
    logic [3:0]         w_len;
    logic [3:0]         w_cnt;
    logic               w_fixed;
    logic               w_err;
    logic               w_beat;

    r_state_t           r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_next;
    logic [3:0]         r_len;
    logic [3:0]         r_cnt;
    logic               r_fixed;

    // Only the word-index bits of the addresses select storage; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    assign w_beat = (w_state == W_DATA) && S_AXI_WVALID && S_AXI_WREADY;
    assign r_next = r_fixed ? r_idx : r_idx + IDX_W'(1);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= '0;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_fixed       <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        S_AXI_BID     <= S_AXI_AWID;
                        w_idx         <= S_AXI_AWADDR[IDX_W+1:2];
                        w_len         <= S_AXI_AWLEN;
                        w_cnt         <= '0;
                        w_fixed       <= (S_AXI_AWBURST == 2'b00);
                        w_err         <= S_AXI_AWBURST[1] || (S_AXI_AWSIZE != SIZE_OK);
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
                        w_cnt <= w_cnt + 4'd1;
                        // Beat count alone ends the burst; WLAST only grades the response.
                        if (w_cnt == w_len) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (w_err || !S_AXI_WLAST) ? 2'b10 : 2'b00;
                            w_state      <= W_RESP;
                        end else if (S_AXI_WLAST) begin
                            w_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        w_state      <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_beat) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RID     <= '0;
            S_AXI_RRESP   <= '0;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_fixed       <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RID     <= S_AXI_ARID;
                        S_AXI_RDATA   <= mem[S_AXI_ARADDR[IDX_W+1:2]];
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RLAST   <= (S_AXI_ARLEN == 4'd0);
                        S_AXI_RRESP   <= (S_AXI_ARBURST[1] || (S_AXI_ARSIZE != SIZE_OK)) ? 2'b10 : 2'b00;
                        r_idx         <= S_AXI_ARADDR[IDX_W+1:2];
                        r_len         <= S_AXI_ARLEN;
                        r_cnt         <= '0;
                        r_fixed       <= (S_AXI_ARBURST == 2'b00);
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID <= 1'b0;
                            S_AXI_RLAST  <= 1'b0;
                            r_state      <= R_IDLE;
                        end else begin
                            // Prefetch the next word on the handshake so RVALID never drops mid-burst.
                            r_idx       <= r_next;
                            S_AXI_RDATA <= mem[r_next];
                            r_cnt       <= r_cnt + 4'd1;
                            S_AXI_RLAST <= ((r_cnt + 4'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
